// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Purpose  : Main control FSM for the multicycle RV32I core. Sequences
//            fetch / decode / execute / memory / writeback by driving the
//            datapath enables and mux selects every cycle. It also decodes
//            the ALU operation and immediate format, and traps unsupported
//            opcodes.
// Ports    : clk, rst_n (synchronous, active-low)
//            op, funct3, funct7b5 : decoded instruction fields
//            zero                 : ALU result == 0
//            pc_write, adr_src, mem_write, ir_write, result_src,
//            alu_src_a, alu_src_b, alu_control, imm_src, reg_write
//                                 : datapath controls
//            illegal              : sticky unsupported-opcode flag
//            state                : current FSM state (debug)
// Options  : MULTICYCLE_CTRL_BNE_EN - the BEQ state also resolves bne
//            (funct3 = 001, taken when zero = 0).
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               zero,
    output logic               pc_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [2:0]         alu_control,
    output logic [1:0]         imm_src,
    output logic               reg_write,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        ILLEGAL  = 4'd15
    } state_t;

    localparam logic [2:0] c_alu_add = 3'b000;
    localparam logic [2:0] c_alu_sub = 3'b001;
    localparam logic [2:0] c_alu_and = 3'b010;
    localparam logic [2:0] c_alu_or  = 3'b011;
    localparam logic [2:0] c_alu_slt = 3'b101;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_illegal;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic [2:0] w_funct_alu;
    logic       w_branch_taken;

    // ------------------------------------------------------------------
    // State register and sticky illegal flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next == ILLEGAL) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // ALU operation for R/I arithmetic. op[5] distinguishes R-type from
    // I-type so that addi with instr[30]=1 is never treated as a subtract.
    // ------------------------------------------------------------------
    always_comb begin
        case (funct3)
            3'b000:  w_funct_alu = (funct7b5 & op[5]) ? c_alu_sub : c_alu_add;
            3'b010:  w_funct_alu = c_alu_slt;
            3'b110:  w_funct_alu = c_alu_or;
            3'b111:  w_funct_alu = c_alu_and;
            default: w_funct_alu = c_alu_add;
        endcase
    end

`ifdef MULTICYCLE_CTRL_BNE_EN
    assign w_branch_taken = ((funct3 == 3'b000) &  zero) |
                            ((funct3 == 3'b001) & ~zero);
`else
    assign w_branch_taken = (funct3 == 3'b000) & zero;
`endif

    // ------------------------------------------------------------------
    // Next-state and per-state datapath controls
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = FETCH;
        w_pc_write   = 1'b0;
        adr_src      = 1'b0;
        w_mem_write  = 1'b0;
        w_ir_write   = 1'b0;
        result_src   = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_control  = c_alu_add;
        imm_src      = 2'b00;
        w_reg_write  = 1'b0;

        case (r_state)
            FETCH: begin
                w_ir_write   = 1'b1;
                alu_src_b    = 2'b10;
                result_src   = 2'b10;
                w_pc_write   = 1'b1;
                w_state_next = DECODE;
            end
            DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    7'b0000011,
                    7'b0100011: w_state_next = MEMADR;
                    7'b0110011: w_state_next = EXECR;
                    7'b0010011: w_state_next = EXECI;
                    7'b1100011: w_state_next = BEQ;
                    7'b1101111: w_state_next = JAL;
                    default:    w_state_next = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                imm_src      = op[5] ? 2'b01 : 2'b00;
                w_state_next = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src      = 1'b1;
                w_state_next = MEMWB;
            end
            MEMWB: begin
                result_src   = 2'b01;
                w_reg_write  = 1'b1;
                w_state_next = FETCH;
            end
            MEMWRITE: begin
                adr_src      = 1'b1;
                w_mem_write  = 1'b1;
                w_state_next = FETCH;
            end
            EXECR: begin
                alu_src_a    = 2'b10;
                alu_control  = w_funct_alu;
                w_state_next = ALUWB;
            end
            EXECI: begin
                alu_src_a    = 2'b10;
                alu_src_b    = 2'b01;
                alu_control  = w_funct_alu;
                w_state_next = ALUWB;
            end
            ALUWB: begin
                w_reg_write  = 1'b1;
                w_state_next = FETCH;
            end
            BEQ: begin
                alu_src_a    = 2'b10;
                alu_control  = c_alu_sub;
                w_pc_write   = w_branch_taken;
                w_state_next = FETCH;
            end
            JAL: begin
                // ALU forms the link value OldPC+4; ALUWB writes it back.
                alu_src_a    = 2'b01;
                alu_src_b    = 2'b10;
                w_pc_write   = 1'b1;
                imm_src      = 2'b11;
                w_state_next = ALUWB;
            end
            ILLEGAL: begin
                w_state_next = ILLEGAL;
            end
            default: begin
                w_state_next = FETCH;
            end
        endcase
    end

    // Write enables are masked during reset so no state is disturbed
    // while the FSM is still being initialised.
    assign pc_write  = rst_n & w_pc_write;
    assign mem_write = rst_n & w_mem_write;
    assign ir_write  = rst_n & w_ir_write;
    assign reg_write = rst_n & w_reg_write;
    assign illegal   = r_illegal;
    assign state     = STATE_W'(r_state);

endmodule
`default_nettype wire
